// File: rtl/prim_reqack_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : prim_reqack_arb_if
// Brief    : Requester-side and channel-side signal bundle of the REQ/ACK arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface prim_reqack_arb_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
);
  localparam int c_idx_w = $clog2(NumReq);

  logic [NumReq-1:0]           req_i;
  logic [NumReq*DataWidth-1:0] data_i;
  logic [NumReq-1:0]           ack_o;
  logic                        chan_req_o;
  logic [DataWidth-1:0]        chan_data_o;
  logic                        chan_ack_i;
  logic [c_idx_w-1:0]          gnt_idx_o;
  logic                        busy_o;
  logic                        timeout_o;

  modport slave (
    input  req_i, data_i, chan_ack_i,
    output ack_o, chan_req_o, chan_data_o, gnt_idx_o, busy_o, timeout_o
  );

  modport master (
    output req_i, data_i, chan_ack_i,
    input  ack_o, chan_req_o, chan_data_o, gnt_idx_o, busy_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/prim_reqack_arb.sv
`default_nettype none
// ============================================================================
// Module   : prim_reqack_arb
// Brief    : Round-robin arbiter sharing one REQ/ACK CDC channel, with timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module prim_reqack_arb #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 8,
  parameter int TimeoutCycles = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  prim_reqack_arb_if.slave  bus
);
  localparam int          c_idx_w    = $clog2(NumReq);
  localparam int unsigned c_num_req_u = NumReq;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e               r_state;
  logic [c_idx_w-1:0]   r_ptr;
  logic [c_idx_w-1:0]   r_gnt_idx;
  logic [DataWidth-1:0] r_chan_data;

  logic [c_idx_w-1:0]   w_sel;
  logic                 w_any;
  logic                 w_start;
  logic                 w_done;
  logic [NumReq-1:0]    w_ack;

  function automatic logic [c_idx_w-1:0] wrap_add(input logic [c_idx_w-1:0] base,
                                                  input int unsigned          off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= c_num_req_u) sum = sum - c_num_req_u;
    return sum[c_idx_w-1:0];
  endfunction

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_sel = r_ptr;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (bus.req_i[wrap_add(r_ptr, unsigned'(i))]) w_sel = wrap_add(r_ptr, unsigned'(i));
    end
  end

  assign w_any   = |bus.req_i;
  assign w_start = (r_state == ST_IDLE) && w_any;
  assign w_done  = (r_state == ST_GRANT) && bus.chan_ack_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_chan_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_GRANT;
            r_gnt_idx   <= w_sel;
            r_chan_data <= bus.data_i[w_sel*DataWidth +: DataWidth];
          end
        end
        ST_GRANT: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_ptr   <= wrap_add(r_gnt_idx, 1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ack = '0;
    if (w_done) w_ack[r_gnt_idx] = 1'b1;
  end

  assign bus.ack_o       = w_ack;
  assign bus.chan_req_o  = (r_state == ST_GRANT);
  assign bus.busy_o      = (r_state == ST_GRANT);
  assign bus.chan_data_o = r_chan_data;
  assign bus.gnt_idx_o   = r_gnt_idx;

  generate
    if (TimeoutCycles > 0) begin : g_timeout
      localparam int                c_cnt_w   = $clog2(TimeoutCycles + 1);
      localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TimeoutCycles);

      logic [c_cnt_w-1:0] r_cnt;
      logic               r_timeout;

      // Counter saturates at the limit, so the pulse fires once per transaction.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end else begin
          r_timeout <= 1'b0;
          if (w_start) begin
            r_cnt <= '0;
          end else if ((r_state == ST_GRANT) && !bus.chan_ack_i && (r_cnt != c_cnt_max)) begin
            r_cnt     <= r_cnt + 1'b1;
            r_timeout <= (r_cnt == c_cnt_max - 1'b1);
          end
        end
      end

      assign bus.timeout_o = r_timeout;
    end else begin : g_no_timeout
      assign bus.timeout_o = 1'b0;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_prim_reqack_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_reqack_arb
// Brief    : Directed self-checking bench for the round-robin REQ/ACK arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_reqack_arb;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  prim_reqack_arb_if #(.NumReq(4), .DataWidth(8)) bus ();

  prim_reqack_arb #(
    .NumReq        (4),
    .DataWidth     (8),
    .TimeoutCycles (5)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction from IDLE: request, grant checks, wait, ack, back to IDLE.
  task automatic txn(input logic [3:0] req, input logic [1:0] idx, input logic [7:0] dat,
                     input int waits, input bit drop);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << idx;
    bus.req_i = req;
    #1 chk("idle_chan_req", 32'(bus.chan_req_o), 32'd0);
    tick();
    chk("grant_chan_req", 32'(bus.chan_req_o), 32'd1);
    chk("grant_idx",      32'(bus.gnt_idx_o),  32'(idx));
    chk("grant_data",     32'(bus.chan_data_o), 32'(dat));
    chk("grant_busy",     32'(bus.busy_o),     32'd1);
    repeat (waits) tick();
    chk("pre_ack_zero",   32'(bus.ack_o),      32'd0);
    bus.chan_ack_i = 1'b1;
    #1 chk("ack_onehot",  32'(bus.ack_o),      32'(one_hot));
    tick();
    bus.chan_ack_i = 1'b0;
    if (drop) bus.req_i = '0;
    #1;
    chk("post_busy",      32'(bus.busy_o),     32'd0);
    chk("post_ack",       32'(bus.ack_o),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.req_i      = '0;
    bus.chan_ack_i = 1'b0;
    bus.data_i     = {8'h33, 8'hA5, 8'h11, 8'h10};
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_chan_req", 32'(bus.chan_req_o),  32'd0);
    chk("rst_busy",     32'(bus.busy_o),      32'd0);
    chk("rst_ack",      32'(bus.ack_o),       32'd0);
    chk("rst_gnt_idx",  32'(bus.gnt_idx_o),   32'd0);
    chk("rst_data",     32'(bus.chan_data_o), 32'd0);
    chk("rst_timeout",  32'(bus.timeout_o),   32'd0);

    // Single request, ACK three cycles after REQ rises; ptr moves to 3.
    txn(4'b0100, 2'd2, 8'hA5, 3, 1'b1);

    // Wrap-around: grant 3, then 1001 picks 0, then 1000 picks 3.
    txn(4'b1000, 2'd3, 8'h33, 0, 1'b1);
    txn(4'b1001, 2'd0, 8'h10, 0, 1'b1);
    txn(4'b1000, 2'd3, 8'h33, 0, 1'b1);

    // Fairness with all requesters held high from ptr=0.
    txn(4'b1111, 2'd0, 8'h10, 0, 1'b0);
    txn(4'b1111, 2'd1, 8'h11, 0, 1'b0);
    txn(4'b1111, 2'd2, 8'hA5, 0, 1'b0);
    txn(4'b1111, 2'd3, 8'h33, 0, 1'b0);
    txn(4'b1111, 2'd0, 8'h10, 0, 1'b1);

    // Payload stability on requester 1 (ptr=1).
    bus.req_i = 4'b0010;
    tick();
    chk("pay_idx",   32'(bus.gnt_idx_o),   32'd1);
    chk("pay_data0", 32'(bus.chan_data_o), 32'h11);
    bus.data_i[15:8] = 8'h22;
    bus.req_i        = 4'b1111;
    tick();
    chk("pay_data1", 32'(bus.chan_data_o), 32'h11);
    chk("pay_idx1",  32'(bus.gnt_idx_o),   32'd1);
    tick();
    bus.chan_ack_i = 1'b1;
    #1;
    chk("pay_ack",   32'(bus.ack_o),       32'h2);
    chk("pay_data2", 32'(bus.chan_data_o), 32'h11);
    bus.req_i = '0;
    tick();
    bus.chan_ack_i = 1'b0;

    // Timeout: grant 2 (ptr=2), ACK withheld for 10 GRANT cycles.
    bus.req_i = 4'b0100;
    tick();
    chk("to_idx", 32'(bus.gnt_idx_o), 32'd2);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("to_pulse_c%0d", c), 32'(bus.timeout_o), (c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("to_req_c%0d", c),   32'(bus.chan_req_o), 32'd1);
      tick();
    end
    bus.chan_ack_i = 1'b1;
    #1;
    chk("to_ack",      32'(bus.ack_o),     32'h4);
    chk("to_no_pulse", 32'(bus.timeout_o), 32'd0);
    bus.req_i = '0;
    tick();
    bus.chan_ack_i = 1'b0;
    #1 chk("to_done_busy", 32'(bus.busy_o), 32'd0);

    // Reset mid-GRANT (ptr=3 -> requester 1 granted with new payload).
    bus.req_i = 4'b0010;
    tick();
    chk("mr_idx",  32'(bus.gnt_idx_o),   32'd1);
    chk("mr_data", 32'(bus.chan_data_o), 32'h22);
    rst_n     = 1'b0;
    bus.req_i = '0;
    tick();
    rst_n = 1'b1;
    chk("mr_chan_req", 32'(bus.chan_req_o),  32'd0);
    chk("mr_busy",     32'(bus.busy_o),      32'd0);
    chk("mr_gnt_idx",  32'(bus.gnt_idx_o),   32'd0);
    chk("mr_data0",    32'(bus.chan_data_o), 32'd0);
    chk("mr_ack",      32'(bus.ack_o),       32'd0);
    chk("mr_timeout",  32'(bus.timeout_o),   32'd0);

    // Stray ACK in IDLE is ignored.
    bus.chan_ack_i = 1'b1;
    #1 chk("stray_ack", 32'(bus.ack_o), 32'd0);
    tick();
    bus.chan_ack_i = 1'b0;
    chk("stray_chan_req", 32'(bus.chan_req_o), 32'd0);
    chk("stray_busy",     32'(bus.busy_o),     32'd0);

    // Pointer is back at 0 after reset.
    txn(4'b1111, 2'd0, 8'h10, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
